// File: rtl/add_sub_serial.sv
// Multi-cycle two's-complement adder/subtractor: WIDTH bits processed SLICE bits per clock,
// LSB slice first, with a start/busy/done handshake and registered result flags.
module add_sub_serial #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             add_sub_sel,
    input  logic             c_in,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);
    localparam int unsigned S  = WIDTH / SLICE;
    localparam int unsigned CW = (S > 1) ? $clog2(S) : 1;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    if (WIDTH < 1 || SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_param_check
        $error("add_sub_serial: SLICE must divide WIDTH and lie in 1..WIDTH");
    end

    logic [0:0]       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, work_q, work_d, out_q;
    logic             sub_q, carry_q;
    logic             c_out_q, ovf_q, zero_q, done_q;

    logic [31:0]      slice_base;
    logic [SLICE-1:0] a_sl, b_sl;
    logic [SLICE:0]   sum_ext;
    logic             ovf_d;
    logic             last;

    assign last = (cnt_q == CW'(S - 1));

    // One extra bit on the slice sum carries the carry-out (add) or the sign of a
    // negative difference, which is exactly the unsigned borrow (subtract).
    always_comb begin
        slice_base = 32'(cnt_q) * SLICE;
        a_sl       = a_q[slice_base +: SLICE];
        b_sl       = b_q[slice_base +: SLICE];
        if (sub_q) begin
            sum_ext = {1'b0, a_sl} - {1'b0, b_sl} - {{SLICE{1'b0}}, carry_q};
        end else begin
            sum_ext = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
        end
        work_d = work_q;
        work_d[slice_base +: SLICE] = sum_ext[SLICE-1:0];
        if (sub_q) begin
            ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (work_d[WIDTH-1] != a_q[WIDTH-1]);
        end else begin
            ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (work_d[WIDTH-1] != a_q[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            work_q  <= '0;
            out_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= inA;
                        b_q     <= inB;
                        sub_q   <= add_sub_sel;
                        carry_q <= c_in;
                        cnt_q   <= '0;
                        work_q  <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    work_q  <= work_d;
                    carry_q <= sum_ext[SLICE];
                    cnt_q   <= cnt_q + 1'b1;
                    if (last) begin
                        out_q   <= work_d;
                        c_out_q <= sum_ext[SLICE];
                        ovf_q   <= ovf_d;
                        zero_q  <= (work_d == '0);
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy  = (state_q == StRun);
    assign done  = done_q;
    assign out   = out_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;
    assign zero  = zero_q;

endmodule

// File: doc/add_sub_serial.md
# add_sub_serial

Parametrised, multi-cycle two's-complement adder/subtractor. It processes a WIDTH-bit operation SLICE bits per clock, LSB slice first, under a start/busy/done handshake. It extends the 1-bit mux-based add/sub cell to full words, registered operands, status flags and a controlled latency. It sits in the datapath as the shared arithmetic unit where area matters more than single-cycle throughput.

## Interface
- WIDTH, 16, operand/result width in bits; must be ≥ 1.
- SLICE, 4, bits processed per cycle.
  - Must satisfy 1 ≤ SLICE ≤ WIDTH and WIDTH % SLICE == 0; any other value is an elaboration error.
  - S = WIDTH/SLICE is the number of compute cycles.

- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- add_sub_sel  input  1  0 = add (A+B+c_in), 1 = subtract (A−B−c_in).
- c_in  input  1  carry-in (add) / borrow-in (subtract).
- inA  input  WIDTH  operand A.
- inB  input  WIDTH  operand B.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: result and flags just updated.
- out  output  WIDTH  result.
- c_out  output  1  carry-out (add) / borrow-out (subtract).
- ovf  output  1  signed overflow.
- zero  output  1  out == 0.

## Operation
- Two states: IDLE (busy=0) and RUN (busy=1).
- **IDLE → RUN:** on an edge with start=1 and busy=0.
  - Latch inA, inB, add_sub_sel and c_in.
  - Clear the slice counter.
  - Seed the internal carry/borrow with c_in.
- **RUN:** each edge computes slice k = counter, bits [k·SLICE +: SLICE].
  - Uses the latched operands and the running carry/borrow.
  - Writes the slice into an internal working register, updates the carry/borrow, and increments the counter.
- **RUN → IDLE:** on the edge that processes slice S−1. On that same edge:
  - out ← the full working result; c_out ← the final carry/borrow.
  - ovf and zero are computed from the full result.
  - done ← 1 for exactly one cycle.
- **Arithmetic:**
  - Add: {c_out, out} = A + B + c_in, computed at WIDTH+1 bits.
  - Subtract: out = (A − B − c_in) mod 2^WIDTH. c_out = 1 iff A < B + c_in (unsigned borrow, not inverted carry).
- **Overflow:**
  - Add: ovf = (A[msb] == B[msb]) && (out[msb] != A[msb]).
  - Subtract: ovf = (A[msb] != B[msb]) && (out[msb] != A[msb]).
- **Output hold:** out, c_out, ovf and zero change only on the completion edge or on reset. They hold the previous result throughout RUN and IDLE.
- **start while busy=1:** ignored. Input changes during RUN have no effect.
- **start on the done cycle:** busy=0 in that cycle, so start is accepted and the next operation begins back-to-back.
- **Reset:**
  - rst=1 on an edge forces IDLE and overrides start.
  - All outputs are cleared: busy=0, done=0, out=0, c_out=0, ovf=0, zero=1 (since out=0).
  - rst mid-RUN aborts the operation; no done is produced for it.

## Timing
- Edge E0 samples start=1 with busy=0. busy=1 after E0.
- Edges E1…ES compute slices 0…S−1.
- After ES: busy=0, done=1, and result/flags are valid.
- Latency from the accepting edge to done = S cycles. Throughput is one operation per S cycles.
- SLICE=WIDTH gives S=1: busy is high one cycle, and done appears in the cycle after acceptance.
- done is never high together with busy. done is high for exactly one cycle per accepted operation.

## Test plan
Use WIDTH=16, SLICE=4 unless stated.
- **Add:** A=0x1234, B=0x0FFF, sel=0, c_in=0 → out=0x2233, c_out=0, ovf=0, zero=0. done exactly 4 cycles after the accepting edge; busy high for those 4 cycles.
- **Subtract with borrow:** A=0x0000, B=0x0001, sel=1, c_in=0 → out=0xFFFF, c_out=1, ovf=0. Separately, A=0x8000, B=0x0001, sel=1 → out=0x7FFF, c_out=0, ovf=1.
- **Carry chain and zero:**
  - A=0xFFFF, B=0x0000, sel=0, c_in=1 → out=0x0000, c_out=1, zero=1.
  - A=0x7FFF, B=0x0001, sel=0 → out=0x8000, ovf=1, c_out=0.
- **Handshake:**
  - start pulsed at cycles 1 and 2 after acceptance, with different operands → ignored; the result matches the first operands.
  - start held high → a new operation is accepted on each done cycle; back-to-back results are correct with no gap.
- **Reset mid-operation:**
  - rst=1 two cycles into RUN → next cycle busy=0, done=0, out=0, c_out=0, ovf=0, zero=1. No done follows.
  - After releasing rst, a new start completes normally.
- **Parameter sweep:**
  - Repeat the add and subtract cases above with SLICE=1 (latency 16) and SLICE=16 (latency 1).
  - Run random operands against a reference model for WIDTH=8, SLICE=2; all of out, c_out, ovf and zero must match.
